rib_arbiter: RTL
================

# rib_arbiter

Request/response-aware arbiter that shares one RIB slave path between up to `MASTER_NUM` masters: ibus, dbus, JTAG debug and a spare. It picks one requesting master and holds that grant through the full transaction, from request handshake to response handshake. A watchdog releases a grant whose response never arrives. It sits inside the RIB interconnect; the master/slave data muxing stays outside and is steered by `grant_o` / `grant_idx_o`.

## Interface
- `MASTER_NUM`, default 4, number of masters (2..8).
- `TIMEOUT`, default 1024, maximum cycles in RSP before forced release (≥2).
- `clk` in 1: single clock, rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `req_vld_i` in MASTER_NUM: per-master request valid.
- `slv_req_rdy_i` in 1: request ready from the addressed slave path.
- `slv_rsp_vld_i` in 1: response valid from the slave path.
- `mst_rsp_rdy_i` in 1: response ready of the currently granted master (muxed outside).
- `grant_o` out MASTER_NUM: one-hot grant, all-zero when idle.
- `grant_idx_o` out $clog2(MASTER_NUM): binary index of the granted master.
- `busy_o` out 1: high in REQ or RSP.
- `timeout_o` out 1: one-cycle pulse on watchdog release.

## Operation
- States:
  - IDLE: no grant.
  - REQ: grant held, waiting for the request handshake.
  - RSP: request accepted, waiting for the response handshake.
- IDLE → REQ:
  - When any `req_vld_i` bit is set, the winner is registered into `grant_o` / `grant_idx_o`.
- REQ → RSP:
  - On `req_vld_i[g] & slv_req_rdy_i`, where g is the granted index.
- REQ → IDLE:
  - If `req_vld_i[g]` drops before the handshake (request withdrawn). Grant cleared, RR pointer not updated.
- RSP → next:
  - On `slv_rsp_vld_i & mst_rsp_rdy_i` the transaction completes.
  - The RR pointer updates to g.
  - In the same cycle a new winner is arbitrated over the current `req_vld_i`, excluding the just-served master only in RR mode.
  - Next state is REQ with the new grant if any request remains, else IDLE. This gives zero-bubble back-to-back transactions.
- Watchdog:
  - A counter clears on entry to RSP and increments each RSP cycle.
  - When it reaches `TIMEOUT-1` without completion: `timeout_o` pulses, grant clears, state goes to IDLE and the RR pointer updates to g.
  - If completion and timeout occur in the same cycle, completion wins and there is no pulse.
- Requests from non-granted masters are ignored until the next arbitration point (IDLE or RSP completion).
- Reset values:
  - `grant_o` = 0, `grant_idx_o` = 0, `busy_o` = 0, `timeout_o` = 0.
  - State IDLE, watchdog counter 0, RR pointer = MASTER_NUM-1 (so master 0 wins first).
- Reset mid-transaction drops the grant immediately (asynchronous). The outside mux must then gate slave valid.

## Timing
- Arbitration latency: 1 cycle from `req_vld_i` seen in IDLE to `grant_o` valid.
- All outputs are registered. There is no combinational path from any input to `grant_o`.
- Minimum transaction: 3 cycles:
  - REQ with immediate `slv_req_rdy_i`;
  - RSP with immediate response;
  - the next grant is visible the cycle after completion.
- `busy_o` equals `|grant_o`.
- Watchdog counter width: $clog2(TIMEOUT). It saturates and never wraps.

## Configuration
- `RIB_ARB_RR_EN` defined:
  - Round-robin arbitration.
  - The search starts at RR pointer+1 modulo MASTER_NUM, so the first requester found wins.
- `RIB_ARB_RR_EN` undefined:
  - Fixed priority, lowest index wins.
  - The RR pointer is not implemented.
  - Excluding the just-served master does not apply.

## Structure
- Shared package `rib_pkg` holds:
  - the state enum `rib_arb_state_e` (IDLE, REQ, RSP);
  - the defaults for `MASTER_NUM` and `TIMEOUT`.
- One sub-module, `rib_arb_pick`: a combinational request vector + pointer → one-hot/index winner, used at both arbitration points.

## Test plan
- Master 1 alone requests, `slv_req_rdy_i` immediate, response after 2 cycles → `grant_o`=4'b0010 one cycle later, `busy_o` high for 4 cycles, then returns to 0.
- Masters 0–3 request continuously, 1-cycle responses, RR build → grants 0,1,2,3,0 in order with no idle cycle between them.
- Same stimulus on a fixed-priority build → master 0 is granted every transaction.
- Master 2 is granted and the response never arrives, `TIMEOUT`=16 → `timeout_o` pulses exactly 16 cycles after entering RSP, grant clears, and master 3 wins next in the RR build.
- Master 0 withdraws `req_vld_i` while in REQ → return to IDLE with `grant_o`=0; the next arbitration still favours master 0 (pointer unchanged).
- `rst_i` asserted mid-RSP with master 1 granted → `grant_o`=0 and `busy_o`=0 asynchronously; after release master 0 wins first.

Source files
------------

// File: rtl/rib_pkg.sv
// Shared definitions for the RIB interconnect arbiter: state encoding and
// default sizing for the master count and the response watchdog.
package rib_pkg;

  localparam int RIB_MASTER_NUM_DEF = 4;
  localparam int RIB_TIMEOUT_DEF    = 1024;

  typedef enum logic [1:0] {
    RIB_ARB_IDLE = 2'd0,
    RIB_ARB_REQ  = 2'd1,
    RIB_ARB_RSP  = 2'd2
  } rib_arb_state_e;

endpackage

// File: rtl/rib_arb_pick.sv
// Combinational winner selection. The search starts at ptr+1 (modulo
// MASTER_NUM) and the first set request bit wins. A pointer of MASTER_NUM-1
// therefore gives plain lowest-index-first priority.
module rib_arb_pick
  import rib_pkg::*;
#(
  parameter int MASTER_NUM = RIB_MASTER_NUM_DEF,
  parameter int IW         = $clog2(MASTER_NUM)
) (
  input  logic [MASTER_NUM-1:0] req,
  input  logic [IW-1:0]         ptr,
  output logic [MASTER_NUM-1:0] grant,
  output logic [IW-1:0]         idx,
  output logic                  any
);

  int          pos;
  logic [IW-1:0] pos_idx;

  // Rotating first-found search over the request vector.
  always_comb begin
    grant   = '0;
    idx     = '0;
    any     = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 0; k < MASTER_NUM; k++) begin
      pos = int'(ptr) + 1 + k;
      if (pos >= MASTER_NUM) pos = pos - MASTER_NUM;
      if (pos >= MASTER_NUM) pos = pos - MASTER_NUM;
      pos_idx = IW'(pos);
      if (!any && req[pos_idx]) begin
        any            = 1'b1;
        grant[pos_idx] = 1'b1;
        idx            = pos_idx;
      end
    end
  end

endmodule

// File: rtl/rib_arbiter.sv
// Transaction-holding arbiter for the shared RIB slave path.
// A grant is taken at an arbitration point (IDLE, or response completion)
// and held until the response handshake, a request withdrawal, or a
// watchdog release after TIMEOUT cycles in RSP.
// Optional feature macro: RIB_ARB_RR_EN selects round-robin arbitration;
// without it the arbiter is fixed priority (lowest index wins).
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. The request handshake is req_vld_i[g] & slv_req_rdy_i for the
// granted master g; the response handshake is slv_rsp_vld_i & mst_rsp_rdy_i.
// Valid is not expected to depend on ready.
module rib_arbiter
  import rib_pkg::*;
#(
  parameter int MASTER_NUM = RIB_MASTER_NUM_DEF,
  parameter int TIMEOUT    = RIB_TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          rst_i,
  input  logic [MASTER_NUM-1:0]         req_vld_i,
  input  logic                          slv_req_rdy_i,
  input  logic                          slv_rsp_vld_i,
  input  logic                          mst_rsp_rdy_i,
  output logic [MASTER_NUM-1:0]         grant_o,
  output logic [$clog2(MASTER_NUM)-1:0] grant_idx_o,
  output logic                          busy_o,
  output logic                          timeout_o,
  output logic [1:0]                    state_o
);

  localparam int               IW      = $clog2(MASTER_NUM);
  localparam int               CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0]    CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0]    PTR_RST = IW'(MASTER_NUM - 1);

  rib_arb_state_e        state_q, state_d;
  logic [MASTER_NUM-1:0] grant_q, grant_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic                  tout_q, tout_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [MASTER_NUM-1:0] pick_req;
  logic [IW-1:0]         pick_ptr;
  logic [MASTER_NUM-1:0] pick_grant;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;

  logic                  g_req;
  logic                  rsp_done;

  assign g_req    = |(req_vld_i & grant_q);
  assign rsp_done = slv_rsp_vld_i & mst_rsp_rdy_i;

`ifdef RIB_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // At completion the served master becomes the new pointer and is kept out
  // of the same-cycle re-arbitration; from IDLE the stored pointer is used.
  always_comb begin
    pick_req = req_vld_i;
    pick_ptr = ptr_q;
    if (state_q == RIB_ARB_RSP) begin
      pick_req = req_vld_i & ~grant_q;
      pick_ptr = idx_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) ptr_q <= PTR_RST;
    else       ptr_q <= ptr_d;
  end
`else
  // Fixed priority: every search starts at master 0.
  always_comb begin
    pick_req = req_vld_i;
    pick_ptr = PTR_RST;
  end
`endif

  rib_arb_pick #(
    .MASTER_NUM (MASTER_NUM),
    .IW         (IW)
  ) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Next-state, next-grant and watchdog logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tout_d  = 1'b0;
`ifdef RIB_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      RIB_ARB_IDLE: begin
        if (pick_any) begin
          state_d = RIB_ARB_REQ;
          grant_d = pick_grant;
          idx_d   = pick_idx;
        end
      end
      RIB_ARB_REQ: begin
        if (!g_req) begin
          // Withdrawn before acceptance: drop the grant, keep the pointer.
          state_d = RIB_ARB_IDLE;
          grant_d = '0;
          idx_d   = '0;
        end else if (slv_req_rdy_i) begin
          state_d = RIB_ARB_RSP;
          cnt_d   = '0;
        end
      end
      RIB_ARB_RSP: begin
        if (rsp_done) begin
`ifdef RIB_ARB_RR_EN
          ptr_d = idx_q;
`endif
          if (pick_any) begin
            state_d = RIB_ARB_REQ;
            grant_d = pick_grant;
            idx_d   = pick_idx;
          end else begin
            state_d = RIB_ARB_IDLE;
            grant_d = '0;
            idx_d   = '0;
          end
        end else if (cnt_q == CNT_MAX) begin
          // Response never came: release the path.
`ifdef RIB_ARB_RR_EN
          ptr_d   = idx_q;
`endif
          tout_d  = 1'b1;
          state_d = RIB_ARB_IDLE;
          grant_d = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RIB_ARB_IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
    busy_d = |grant_d;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RIB_ARB_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      tout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o     = grant_q;
  assign grant_idx_o = idx_q;
  assign busy_o      = busy_q;
  assign timeout_o   = tout_q;
  assign state_o     = state_q;

endmodule
